// File: rtl/pipeline_swap_ctrl_pkg.sv
// rtl/pipeline_swap_ctrl_pkg.sv - opcodes and FSM states shared by the swap sequencer
package pipeline_swap_ctrl_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_SWAP = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_SWAP_WAIT,
    ST_FADE
  } state_e;

endpackage

// File: rtl/pipeline_swap_ctrl_crossfader.sv
// rtl/pipeline_swap_ctrl_crossfader.sv - sample_crossfader: weight counter and two-stage mixer
// Only built with PIPELINE_SWAP_CROSSFADE_EN defined.
`ifdef PIPELINE_SWAP_CROSSFADE_EN
module sample_crossfader #(
  parameter int data_width = 16,
  parameter int fade_log2  = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         strobe,
  input  logic                         fade_start,
  input  logic signed [data_width-1:0] sample_new,
  input  logic signed [data_width-1:0] sample_old,
  output logic signed [data_width-1:0] out_sample,
  output logic                         out_valid,
  output logic                         fade_last
);

  localparam int PW = data_width + fade_log2 + 1;
  localparam int KI = 1 << fade_log2;
  localparam logic [fade_log2:0] K      = (fade_log2 + 1)'(KI);
  localparam logic [fade_log2:0] K_LAST = (fade_log2 + 1)'(KI - 1);

  logic [fade_log2:0]          k_q, k_d, w;
  logic                        active_q, active_d, fading;
  logic signed [PW-1:0]        p_old_q, p_old_d, p_new_q, p_new_d;
  logic signed [PW-1:0]        old_x, new_x, w_old_x, w_new_x, sum;
  logic                        v1_q, v1_d, valid_q, valid_d;
  logic signed [data_width-1:0] out_q, out_d;

  always_comb begin
    fading    = fade_start | active_q;
    // Outside a fade the new pipeline gets full weight, so latency stays constant.
    w         = fade_start ? '0 : (active_q ? k_q : K);
    fade_last = strobe & fading & (w == K_LAST);
    k_d       = k_q;
    active_d  = active_q;
    if (strobe && fading) begin
      active_d = !fade_last;
      k_d      = fade_last ? '0 : w + 1'b1;
    end
    old_x   = PW'(sample_old);
    new_x   = PW'(sample_new);
    w_old_x = PW'(K - w);
    w_new_x = PW'(w);
    p_old_d = p_old_q;
    p_new_d = p_new_q;
    if (strobe) begin
      p_old_d = old_x * w_old_x;
      p_new_d = new_x * w_new_x;
    end
    v1_d    = strobe;
    sum     = p_old_q + p_new_q;
    out_d   = v1_q ? data_width'(sum >>> fade_log2) : out_q;
    valid_d = v1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q      <= '0;
      active_q <= 1'b0;
      p_old_q  <= '0;
      p_new_q  <= '0;
      v1_q     <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      k_q      <= k_d;
      active_q <= active_d;
      p_old_q  <= p_old_d;
      p_new_q  <= p_new_d;
      v1_q     <= v1_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  assign out_sample = out_q;
  assign out_valid  = valid_q;

endmodule
`endif

// File: rtl/pipeline_swap_ctrl.sv
// rtl/pipeline_swap_ctrl.sv - SPI config parser and A/B pipeline swap sequencer
// PIPELINE_SWAP_CROSSFADE_EN selects a crossfaded swap instead of a hard switch.
module pipeline_swap_ctrl
  import pipeline_swap_ctrl_pkg::*;
#(
  parameter int data_width = 16,
  parameter int fade_log2  = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   fifo_data,
  input  logic                         fifo_nonempty,
  output logic                         fifo_read,
  output logic [7:0]                   cfg_byte,
  output logic                         cfg_ready_a,
  output logic                         cfg_ready_b,
  input  logic                         cfg_read_a,
  input  logic                         cfg_read_b,
  input  logic                         ready_a,
  input  logic                         ready_b,
  input  logic                         error_a,
  input  logic                         error_b,
  input  logic                         out_strobe,
  input  logic signed [data_width-1:0] sample_a,
  input  logic signed [data_width-1:0] sample_b,
  output logic signed [data_width-1:0] out_sample,
  output logic                         out_valid,
  output logic                         current,
  output logic                         swapping,
  output logic                         bad_cmd,
  output logic                         swap_fail
);

  state_e     state_q, state_d, ctx_q, ctx_d;
  logic       fresh_q, fresh_d, armed_q, armed_d;
  logic [7:0] count_q, count_d, cfg_byte_q, cfg_byte_d;
  logic       fifo_read_q, fifo_read_d, cfg_ready_a_q, cfg_ready_a_d;
  logic       cfg_ready_b_q, cfg_ready_b_d, current_q, current_d;
  logic       swapping_q, swapping_d, bad_cmd_q, bad_cmd_d, swap_fail_q, swap_fail_d;
  logic       ready_x, error_x, cfg_read_x, swap_now, sel_b;

  assign ready_x    = current_q ? ready_a : ready_b;
  assign error_x    = current_q ? error_a : error_b;
  assign cfg_read_x = current_q ? cfg_read_a : cfg_read_b;
  // armed_q lags ready_x, so a strobe coinciding with ready rising is ignored.
  assign swap_now   = (state_q == ST_SWAP_WAIT) && !error_x && armed_q && ready_x && out_strobe;
  assign sel_b      = current_q ^ swap_now;

`ifdef PIPELINE_SWAP_CROSSFADE_EN
  logic fade_last;

  sample_crossfader #(.data_width(data_width), .fade_log2(fade_log2)) u_fader (
    .clk        (clk),
    .reset      (reset),
    .strobe     (out_strobe),
    .fade_start (swap_now),
    .sample_new (sel_b ? sample_b : sample_a),
    .sample_old (sel_b ? sample_a : sample_b),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .fade_last  (fade_last)
  );
`else
  logic signed [data_width-1:0] out_sample_q, out_sample_d;
  logic                         out_valid_q;

  always_comb begin
    out_sample_d = out_sample_q;
    if (out_strobe) out_sample_d = sel_b ? sample_b : sample_a;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_strobe;
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;
`endif

  always_comb begin
    state_d       = state_q;
    ctx_d         = ctx_q;
    fresh_d       = 1'b0;
    armed_d       = armed_q;
    count_d       = count_q;
    cfg_byte_d    = cfg_byte_q;
    fifo_read_d   = 1'b0;
    cfg_ready_a_d = cfg_ready_a_q;
    cfg_ready_b_d = cfg_ready_b_q;
    current_d     = current_q;
    swapping_d    = swapping_q;
    bad_cmd_d     = bad_cmd_q;
    swap_fail_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (fifo_nonempty) begin
        fifo_read_d = 1'b1;
        ctx_d       = ST_CMD;
        state_d     = ST_FETCH;
      end
      ST_FETCH: begin
        fresh_d = 1'b1;
        state_d = ctx_q;
      end
      ST_CMD: case (fifo_data)
        CMD_LOAD: state_d = ST_LEN;
        CMD_SWAP: begin
          state_d    = ST_SWAP_WAIT;
          swapping_d = 1'b1;
          armed_d    = 1'b0;
        end
        default: begin
          bad_cmd_d = 1'b1;
          state_d   = ST_IDLE;
        end
      endcase
      ST_LEN: if (fresh_q) begin
        count_d = fifo_data;
        state_d = (fifo_data == 8'd0) ? ST_IDLE : ST_PAYLOAD;
      end else if (fifo_nonempty) begin
        fifo_read_d = 1'b1;
        ctx_d       = ST_LEN;
        state_d     = ST_FETCH;
      end
      ST_PAYLOAD: if (fresh_q) begin
        cfg_byte_d    = fifo_data;
        cfg_ready_a_d = current_q;
        cfg_ready_b_d = !current_q;
      end else if (cfg_ready_a_q || cfg_ready_b_q) begin
        if (cfg_read_x) begin
          cfg_ready_a_d = 1'b0;
          cfg_ready_b_d = 1'b0;
          count_d       = count_q - 8'd1;
          if (count_q == 8'd1) state_d = ST_IDLE;
        end
      end else if (fifo_nonempty) begin
        fifo_read_d = 1'b1;
        ctx_d       = ST_PAYLOAD;
        state_d     = ST_FETCH;
      end
      ST_SWAP_WAIT: begin
        armed_d = ready_x;
        if (error_x) begin
          swap_fail_d = 1'b1;
          swapping_d  = 1'b0;
          state_d     = ST_IDLE;
        end else if (swap_now) begin
          current_d = !current_q;
`ifdef PIPELINE_SWAP_CROSSFADE_EN
          state_d    = fade_last ? ST_IDLE : ST_FADE;
          swapping_d = !fade_last;
`else
          state_d    = ST_IDLE;
          swapping_d = 1'b0;
`endif
        end
      end
      ST_FADE: begin
`ifdef PIPELINE_SWAP_CROSSFADE_EN
        if (fade_last) begin
          state_d    = ST_IDLE;
          swapping_d = 1'b0;
        end
`else
        state_d    = ST_IDLE;
        swapping_d = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ctx_q         <= ST_CMD;
      fresh_q       <= 1'b0;
      armed_q       <= 1'b0;
      count_q       <= 8'd0;
      cfg_byte_q    <= 8'd0;
      fifo_read_q   <= 1'b0;
      cfg_ready_a_q <= 1'b0;
      cfg_ready_b_q <= 1'b0;
      current_q     <= 1'b0;
      swapping_q    <= 1'b0;
      bad_cmd_q     <= 1'b0;
      swap_fail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctx_q         <= ctx_d;
      fresh_q       <= fresh_d;
      armed_q       <= armed_d;
      count_q       <= count_d;
      cfg_byte_q    <= cfg_byte_d;
      fifo_read_q   <= fifo_read_d;
      cfg_ready_a_q <= cfg_ready_a_d;
      cfg_ready_b_q <= cfg_ready_b_d;
      current_q     <= current_d;
      swapping_q    <= swapping_d;
      bad_cmd_q     <= bad_cmd_d;
      swap_fail_q   <= swap_fail_d;
    end
  end

  assign fifo_read   = fifo_read_q;
  assign cfg_byte    = cfg_byte_q;
  assign cfg_ready_a = cfg_ready_a_q;
  assign cfg_ready_b = cfg_ready_b_q;
  assign current     = current_q;
  assign swapping    = swapping_q;
  assign bad_cmd     = bad_cmd_q;
  assign swap_fail   = swap_fail_q;

endmodule

// File: tb/tb_pipeline_swap_ctrl.sv
// tb/tb_pipeline_swap_ctrl.sv - directed bench for pipeline_swap_ctrl (PIPELINE_SWAP_CROSSFADE_EN aware)
module tb_pipeline_swap_ctrl;

`ifdef PIPELINE_SWAP_CROSSFADE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [7:0]         fifo_data = 8'd0;
  logic               fifo_nonempty = 1'b0;
  logic               fifo_read;
  logic [7:0]         cfg_byte;
  logic               cfg_ready_a, cfg_ready_b;
  logic               cfg_read_a = 1'b0, cfg_read_b = 1'b0;
  logic               ready_a, ready_b, error_a, error_b, out_strobe;
  logic signed [15:0] sample_a, sample_b, out_sample;
  logic               out_valid, current, swapping, bad_cmd, swap_fail;

  pipeline_swap_ctrl #(.data_width(16), .fade_log2(2)) dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_nonempty(fifo_nonempty),
    .fifo_read(fifo_read), .cfg_byte(cfg_byte), .cfg_ready_a(cfg_ready_a),
    .cfg_ready_b(cfg_ready_b), .cfg_read_a(cfg_read_a), .cfg_read_b(cfg_read_b),
    .ready_a(ready_a), .ready_b(ready_b), .error_a(error_a), .error_b(error_b),
    .out_strobe(out_strobe), .sample_a(sample_a), .sample_b(sample_b),
    .out_sample(out_sample), .out_valid(out_valid), .current(current),
    .swapping(swapping), .bad_cmd(bad_cmd), .swap_fail(swap_fail)
  );

  logic [7:0] fifo_q[$];
  logic [7:0] recv_a[$];
  logic [7:0] recv_b[$];
  int pops = 0, underflow = 0, a_cycles = 0, b_cycles = 0, both_cnt = 0, fail_cnt = 0;
  logic auto_a = 1'b0, auto_b = 1'b0;
  int errors = 0, checks = 0;

  always @(posedge clk) begin
    if (fifo_read) begin
      pops++;
      if (fifo_q.size() == 0) underflow++;
      else fifo_data <= fifo_q.pop_front();
    end
    if (cfg_ready_a && cfg_read_a) recv_a.push_back(cfg_byte);
    if (cfg_ready_b && cfg_read_b) recv_b.push_back(cfg_byte);
    if (cfg_ready_a) a_cycles++;
    if (cfg_ready_b) b_cycles++;
    if (cfg_ready_a && cfg_ready_b) both_cnt++;
    if (swap_fail) fail_cnt++;
  end

  always @(negedge clk) begin
    fifo_nonempty = (fifo_q.size() != 0);
    cfg_read_a = auto_a & cfg_ready_a;
    cfg_read_b = auto_b & cfg_ready_b;
  end

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               strobe;
    logic signed [15:0] exp_out;
    logic               exp_valid;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  int base, bsnap, nb, unstable;
  int fexp[5];

  initial begin
    vecs[0] = '{16'sd100,    -16'sd5,    1'b1, 16'sd100,    1'b1};
    vecs[1] = '{16'sd7,      16'sd8,     1'b0, 16'sd100,    1'b0};
    vecs[2] = '{-16'sd32768, 16'sd32767, 1'b1, -16'sd32768, 1'b1};
    vecs[3] = '{16'sd32767,  16'sd0,     1'b1, 16'sd32767,  1'b1};
    vecs[4] = '{16'sd1,      16'sd2,     1'b0, 16'sd32767,  1'b0};
    fexp = '{1000, 500, 0, -500, -1000};

    reset = 1'b0;
    ready_a = 0; ready_b = 0; error_a = 0; error_b = 0;
    out_strobe = 0; sample_a = 0; sample_b = 0;
    repeat (3) @(negedge clk);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_cfg_byte", cfg_byte, 0);
    check("rst_cfg_ready_a", cfg_ready_a, 0);
    check("rst_cfg_ready_b", cfg_ready_b, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_current", current, 0);
    check("rst_swapping", swapping, 0);
    check("rst_bad_cmd", bad_cmd, 0);
    check("rst_swap_fail", swap_fail, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      sample_a = vecs[i].a; sample_b = vecs[i].b; out_strobe = vecs[i].strobe;
      @(negedge clk);
      out_strobe = 0;
      repeat (LAT - 1) @(negedge clk);
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_sample", i), out_sample, vecs[i].exp_out);
    end

    // LOAD 3 bytes to the inactive pipeline B
    auto_b = 1; base = pops;
    push(8'h01); push(8'h03); push(8'hAA); push(8'hBB); push(8'hCC);
    for (int i = 0; i < 100 && recv_b.size() < 3; i++) @(negedge clk);
    check("load_recv_count", recv_b.size(), 3);
    check("load_byte0", recv_b[0], 8'hAA);
    check("load_byte1", recv_b[1], 8'hBB);
    check("load_byte2", recv_b[2], 8'hCC);
    check("load_no_ready_a", a_cycles, 0);
    check("load_pops", pops - base, 5);

    // Withheld cfg_read_b: byte held, no pops while waiting
    auto_b = 0; base = pops;
    push(8'h01); push(8'h01); push(8'h5A);
    for (int i = 0; i < 50 && !cfg_ready_b; i++) @(negedge clk);
    check("hold_ready_b", cfg_ready_b, 1);
    push(8'h7F); push(8'h01); push(8'h00);
    unstable = 0;
    repeat (20) begin
      @(negedge clk);
      if (cfg_ready_b !== 1'b1 || cfg_byte !== 8'h5A || cfg_ready_a !== 1'b0) unstable++;
    end
    check("hold_stable", unstable, 0);
    check("hold_pops", pops - base, 3);
    nb = recv_b.size(); auto_b = 1;
    for (int i = 0; i < 20 && recv_b.size() <= nb; i++) @(negedge clk);
    check("hold_recv_count", recv_b.size(), nb + 1);
    check("hold_byte", recv_b[nb], 8'h5A);
    bsnap = b_cycles;
    repeat (30) @(negedge clk);
    check("bad_cmd_sticky", bad_cmd, 1);
    check("len0_no_ready", b_cycles, bsnap);
    check("len0_pops", pops - base, 6);

    // SWAP rejected by error_b
    error_b = 1;
    push(8'h02);
    for (int i = 0; i < 30 && fail_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("fail_pulse_count", fail_cnt, 1);
    check("fail_current", current, 0);
    check("fail_swapping", swapping, 0);
    error_b = 0;
    nb = recv_b.size();
    push(8'h01); push(8'h01); push(8'h33);
    for (int i = 0; i < 50 && recv_b.size() <= nb; i++) @(negedge clk);
    check("post_fail_recv_count", recv_b.size(), nb + 1);
    check("post_fail_byte", recv_b[nb], 8'h33);
    check("post_fail_no_ready_a", a_cycles, 0);

    // SWAP: strobe coinciding with ready_b rising is ignored, next strobe swaps
    push(8'h02);
    for (int i = 0; i < 30 && !swapping; i++) @(negedge clk);
    check("swap_wait_swapping", swapping, 1);
    sample_a = 111; sample_b = 222; ready_b = 1; out_strobe = 1;
    @(negedge clk);
    out_strobe = 0;
    check("same_cycle_no_swap", current, 0);
    @(negedge clk);
`ifndef PIPELINE_SWAP_CROSSFADE_EN
    out_strobe = 1;
    @(negedge clk);
    out_strobe = 0;
    check("swap_current", current, 1);
    check("swap_valid", out_valid, 1);
    check("swap_sample_b", out_sample, 222);
    check("swap_done", swapping, 0);
`else
    sample_a = 1000; sample_b = -1000; out_strobe = 1;
    @(negedge clk);
    out_strobe = 0;
    check("swap_current", current, 1);
    check("fade_swapping", swapping, 1);
    @(negedge clk);
    check("fade_out0", out_sample, fexp[0]);
    for (int j = 1; j < 5; j++) begin
      out_strobe = 1;
      @(negedge clk);
      out_strobe = 0;
      check($sformatf("fade_swapping%0d", j), swapping, (j < 3) ? 1 : 0);
      @(negedge clk);
      check($sformatf("fade_out%0d", j), out_sample, fexp[j]);
    end
`endif

    // After the swap, LOAD targets pipeline A
    bsnap = b_cycles; auto_a = 1;
    push(8'h01); push(8'h01); push(8'h44);
    for (int i = 0; i < 50 && recv_a.size() < 1; i++) @(negedge clk);
    check("after_swap_recv_a", recv_a.size(), 1);
    check("after_swap_byte", recv_a[0], 8'h44);
    check("after_swap_no_ready_b", b_cycles, bsnap);
    check("no_underflow_pop", underflow, 0);
    check("never_both_ready", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
